fir_result_buffer: RTL
======================

# fir_result_buffer

Downstream stage of the HLS FIR filter IP. It captures every `output_r` word qualified by `result_valid` into a small FIFO and re-emits the words on a valid/ready stream. Each stream word carries a frame marker, so the consumer (DMA/UART packer) can take data at its own pace. Overflow is detected and reported instead of silently corrupting data.

## Interface
Parameters:
- `DATA_W`, 32, width of filter result words.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `FRAME_LEN`, 20, words per frame; ≥ 1; `m_last` marks the last word of each frame.

Ports:
- `ap_clk`  in  1  single clock; all logic rising-edge.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `result_r`  in  DATA_W  FIR output word (from `output_r`).
- `result_valid`  in  1  one-cycle qualifier per FIR result.
- `m_data`  out  DATA_W  head-of-FIFO word.
- `m_valid`  out  1  `m_data`/`m_last` valid.
- `m_ready`  in  1  consumer accepts word.
- `m_last`  out  1  head word is the FRAME_LEN-th word of its frame.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky; set on first dropped word.
- `ovf_count`  out  16  dropped-word count; present only with `FIR_BUF_OVF_CNT_EN`.

## Operation
- Write: `push = result_valid & ~full`; stores `result_r` at `wr_ptr`, `wr_ptr` wraps modulo DEPTH.
- Drop: `result_valid & full` discards the word and sets `overflow`. `overflow` clears only on reset.
- A drop occurs while full even if a pop happens in the same cycle. `full` is the registered occupancy; there is no write-through on pop.
- Read: `pop = m_valid & m_ready`; advances `rd_ptr` (wraps).
- `m_valid = (level != 0)`. `m_data = mem[rd_ptr]`, show-ahead from registered storage.
- `m_data`/`m_last` hold stable while `m_valid & ~m_ready`.
- Level update: +1 on push only, −1 on pop only, unchanged on push & pop.
  - Push & pop at `level == 0` is impossible because `m_valid = 0`.
  - Push & pop at `level == DEPTH` cannot happen either: the push is a drop there, so the pop proceeds alone.
- Frame counter `fcnt` (0..FRAME_LEN−1) counts pops.
  - `m_last = m_valid & (fcnt == FRAME_LEN−1)`.
  - On pop, `fcnt` wraps to 0 after FRAME_LEN−1.
  - `FRAME_LEN == 1` → `m_last` equals `m_valid`.
  - Dropped words do not advance `fcnt`; frames count delivered words.
- Reset mid-operation: pointers, `level`, `fcnt`, `overflow`, and `ovf_count` clear in the reset cycle. FIFO contents are discarded (memory need not be cleared). `result_valid` during reset is ignored.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `level=0`, `full=0`, `overflow=0`, `ovf_count=0`. `m_data` is don't-care while `m_valid=0`.
- Latency: a push in cycle N → `m_valid=1` with that word in cycle N+1.
- Pop in cycle N → next word (or `m_valid=0`) in cycle N+1.
- `full` and `level` update the cycle after the causing push/pop.
- `overflow` rises the cycle after the first drop.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `FIR_BUF_OVF_CNT_EN` defined: `ovf_count` port exists.
  - Increments by 1 per dropped word and saturates at 16'hFFFF.
  - Clears on reset.
- Not defined: the port and counter are absent. `overflow` remains.

## Structure
- Shared package `fir_pkg`: `FIR_DATA_W = 32`, `FIR_FRAME_LEN_DEF = 20`, result word typedef `fir_word_t`.
- One sub-module `fir_buf_ram`: DEPTH×DATA_W register array with one write port and asynchronous read.
- Pointer, level, frame, and overflow logic live in the top module.

## Test plan
- Reset then 3 pushes (0x11, 0x22, 0x33) with `m_ready=0`: `level=3`, `m_data=0x11` held. With `m_ready=1` for 3 cycles, the words come out in order and `m_valid` drops in the 4th cycle.
- Continuous `result_valid` with `m_ready=1`, 45 words 1..45: all delivered in order, no overflow. `m_last` is high on words 20 and 40 only; `fcnt=5` at end.
- `m_ready=0`, 18 pushes with DEPTH=16: `full=1` after the 16th. Words 17 and 18 are dropped, `overflow=1`, `ovf_count=2` (macro on). A drain yields 1..16.
- At `full`, same-cycle push of 0xAA and pop: the pop is taken, 0xAA is dropped, `level=15`, `ovf_count` +1.
- `m_ready` toggling 1/0 while pushing each cycle: no data loss until `level` reaches 16; `m_data` stays stable on stalled cycles.
- `ap_rst_n=0` for one cycle with `level=7`, `fcnt=9`, `overflow=1`: next cycle `level=0`, `m_valid=0`, `overflow=0`. A following frame asserts `m_last` on its 20th word.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the FIR result path.
//   FIR_DATA_W        - width of one filter result word
//   FIR_FRAME_LEN_DEF - default number of words per frame
//   fir_word_t        - one result word at the default width
package fir_pkg;
  localparam int FIR_DATA_W        = 32;
  localparam int FIR_FRAME_LEN_DEF = 20;
  typedef logic [FIR_DATA_W-1:0] fir_word_t;
endpackage

// File: rtl/fir_buf_ram.sv
// fir_buf_ram: DEPTH x DATA_W register array used as FIFO storage.
// Ports:
//   clk_i   - rising-edge clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (asynchronous read)
// Contents are deliberately not reset; the owning FIFO tracks which
// entries are live.
module fir_buf_ram
  import fir_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = FIR_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_result_buffer.sv
// fir_result_buffer: captures FIR results into a show-ahead FIFO and
// re-emits them on a valid/ready stream with a per-frame last marker.
// Ports:
//   ap_clk, ap_rst_n      - clock, synchronous active-low reset
//   result_r/result_valid - FIR result word and its one-cycle qualifier
//   m_data/m_valid/m_last - head-of-FIFO word, valid, last-of-frame
//   m_ready               - consumer accepts the head word
//   level, full           - registered occupancy (0..DEPTH), level==DEPTH
//   overflow              - sticky flag, set by the first dropped word
//   ovf_count             - saturating dropped-word count, only when the
//                           macro FIR_BUF_OVF_CNT_EN is defined
module fir_result_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W    = FIR_DATA_W,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = FIR_FRAME_LEN_DEF,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] result_r,
  input  logic              result_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              overflow
`ifdef FIR_BUF_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  // Frame counter needs at least one bit even when FRAME_LEN == 1.
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  // full comes from registered occupancy: a pop in the same cycle does
  // not make room for an incoming word.
  assign full    = (level_q == LW'(DEPTH));
  assign m_valid = (level_q != '0);
  assign push    = result_valid & ~full;
  assign drop    = result_valid & full;
  assign pop     = m_valid & m_ready;

  assign level    = level_q;
  assign overflow = ovf_q;
  assign m_last   = m_valid & (fcnt_q == FW'(FRAME_LEN - 1));

  fir_buf_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk_i   (ap_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (result_r),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q | drop;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      fcnt_d   = (fcnt_q == FW'(FRAME_LEN - 1)) ? '0 : fcnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FIR_BUF_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturate rather than wrap so a long overflow burst never reads as small.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) ovf_cnt_q <= '0;
    else           ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule
